// File: rtl/histo_pkg.sv
// Shared types and helpers for the histogram/threshold engine.
// Counter helpers assume CNT_W <= 31.
package histo_pkg;

   localparam int unsigned DEF_PIX_W = 8;
   localparam int unsigned DEF_CNT_W = 20;

   typedef enum logic [2:0] {
      StInitClear,
      StIdle,
      StAccum,
      StFlush,
      StScan,
      StPublish,
      StClear
   } state_e;

   function automatic int unsigned num_bins(input int unsigned pix_w);
      return 32'd1 << pix_w;
   endfunction

   function automatic int unsigned thresh_rst_default(input int unsigned pix_w);
      return 32'd1 << (pix_w - 32'd1);
   endfunction

   function automatic logic [31:0] cnt_max(input int unsigned cnt_w);
      return (32'd1 << cnt_w) - 32'd1;
   endfunction

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned cnt_w);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s > {1'b0, cnt_max(cnt_w)}) begin
         return cnt_max(cnt_w);
      end
      return s[31:0];
   endfunction

endpackage

// File: rtl/histo_bank_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-first).
module histo_bank_ram #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 20
) (
   input  logic          iClk,
   input  logic          iWe,
   input  logic [AW-1:0] iWaddr,
   input  logic [DW-1:0] iWdata,
   input  logic [AW-1:0] iRaddr,
   output logic [DW-1:0] oRdata
);

   logic [DW-1:0] mem [0:(1 << AW) - 1];

   always_ff @(posedge iClk) begin
      if (iWe) begin
         mem[iWaddr] <= iWdata;
      end
      oRdata <= mem[iRaddr];
   end

endmodule

// File: rtl/histo_thresh_engine.sv
// Per-frame gray histogram with ping-pong banks, cumulative scan, percentile threshold
// and a free-running binariser.
module histo_thresh_engine
   import histo_pkg::*;
#(
   parameter int unsigned      PIX_W      = DEF_PIX_W,
   parameter int unsigned      CNT_W      = DEF_CNT_W,
   parameter logic [PIX_W-1:0] THRESH_RST = PIX_W'(thresh_rst_default(PIX_W))
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iFval,
   input  logic [PIX_W-1:0] iGray,
   input  logic             iGrayValid,
   input  logic [CNT_W-1:0] iTarget,
   input  logic             iManual,
   input  logic [PIX_W-1:0] iManualThresh,
   input  logic [PIX_W-1:0] iRdAddr,
   output logic [CNT_W-1:0] oHisto,
   output logic [CNT_W-1:0] oCumHisto,
   output logic [CNT_W-1:0] oMaxValue,
   output logic [PIX_W-1:0] oThresh,
   output logic [PIX_W-1:0] oPixel,
   output logic             oPixelValid,
   output logic             oDone,
   output logic             oOverrun
);

   localparam logic [PIX_W-1:0] PIX_ONE = PIX_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state_q, state_d;
   logic [PIX_W-1:0] cnt_q, cnt_d;
   logic             fval_q, fval_rise, fval_fall;
   logic             clr_we, init_clr, publish, scanning, pix_accept;

   logic             acc_bank_q;
   logic             disp_sel_q, disp_en_q;

   logic             s1_valid_q, s2_valid_q;
   logic [PIX_W-1:0] s1_addr_q, s2_addr_q;
   logic [CNT_W-1:0] s2_data_q;
   logic [CNT_W-1:0] inc_base, inc_data;

   logic [CNT_W-1:0] target_q, sum_q, sum_d, max_q;
   logic [PIX_W-1:0] thr_q;
   logic             found_q;

   logic [CNT_W-1:0] max_out_q;
   logic [PIX_W-1:0] thresh_q, pix_q;
   logic             pix_valid_q, done_q, overrun_q;

   logic             acc_we, we_a, we_b, we_c;
   logic [PIX_W-1:0] bank_waddr, acc_raddr, scan_raddr, raddr_a, raddr_b;
   logic [CNT_W-1:0] bank_wdata, cum_wdata;
   logic [CNT_W-1:0] rd_a, rd_b, rd_c, acc_rdata;

   assign fval_rise  = iFval & ~fval_q;
   assign fval_fall  = ~iFval & fval_q;
   assign init_clr   = (state_q == StInitClear);
   assign publish    = (state_q == StPublish);
   assign scanning   = (state_q == StScan);
   assign pix_accept = (state_q == StAccum) & iGrayValid;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_we  = 1'b0;
      unique case (state_q)
         StInitClear: begin
            clr_we = 1'b1;
            cnt_d  = cnt_q + PIX_ONE;
            if (cnt_q == '1) state_d = StIdle;
         end
         StIdle: begin
            cnt_d = '0;
            if (fval_rise) state_d = StAccum;
         end
         StAccum: begin
            cnt_d = '0;
            if (fval_fall) state_d = StFlush;
         end
         StFlush: begin
            cnt_d = cnt_q + PIX_ONE;
            if (cnt_q == PIX_ONE) begin
               state_d = StScan;
               cnt_d   = '0;
            end
         end
         StScan: begin
            cnt_d = cnt_q + PIX_ONE;
            if (cnt_q == '1) state_d = StPublish;
         end
         StPublish: begin
            cnt_d   = '0;
            state_d = StClear;
         end
         StClear: begin
            clr_we = 1'b1;
            cnt_d  = cnt_q + PIX_ONE;
            if (cnt_q == '1) state_d = StIdle;
         end
         default: begin
            state_d = StInitClear;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= StInitClear;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Last write landed on the same edge as this read, so the RAM returned the stale value.
   assign inc_base = (s2_valid_q && (s2_addr_q == s1_addr_q)) ? s2_data_q : acc_rdata;
   assign inc_data = CNT_W'(sat_add(32'(inc_base), 32'(CNT_ONE), CNT_W));
   assign sum_d    = CNT_W'(sat_add(32'(sum_q), 32'(acc_rdata), CNT_W));

   // Scan reads run one bin ahead; bin 0 is fetched in the last flush cycle.
   assign scan_raddr = scanning ? (cnt_q + PIX_ONE) : '0;
   assign acc_raddr  = (state_q == StAccum) ? iGray : scan_raddr;
   assign raddr_a    = acc_bank_q ? iRdAddr : acc_raddr;
   assign raddr_b    = acc_bank_q ? acc_raddr : iRdAddr;
   assign acc_rdata  = acc_bank_q ? rd_b : rd_a;

   assign acc_we     = clr_we | s1_valid_q;
   assign bank_waddr = clr_we ? cnt_q : s1_addr_q;
   assign bank_wdata = clr_we ? '0 : inc_data;
   assign we_a       = init_clr | (~acc_bank_q & acc_we);
   assign we_b       = init_clr | (acc_bank_q & acc_we);
   assign we_c       = init_clr | scanning;
   assign cum_wdata  = init_clr ? '0 : sum_d;

   histo_bank_ram #(.AW(PIX_W), .DW(CNT_W)) u_bank_a (
      .iClk   (iClk),
      .iWe    (we_a),
      .iWaddr (bank_waddr),
      .iWdata (bank_wdata),
      .iRaddr (raddr_a),
      .oRdata (rd_a)
   );

   histo_bank_ram #(.AW(PIX_W), .DW(CNT_W)) u_bank_b (
      .iClk   (iClk),
      .iWe    (we_b),
      .iWaddr (bank_waddr),
      .iWdata (bank_wdata),
      .iRaddr (raddr_b),
      .oRdata (rd_b)
   );

   histo_bank_ram #(.AW(PIX_W), .DW(CNT_W)) u_cum (
      .iClk   (iClk),
      .iWe    (we_c),
      .iWaddr (cnt_q),
      .iWdata (cum_wdata),
      .iRaddr (iRdAddr),
      .oRdata (rd_c)
   );

   always_ff @(posedge iClk) begin
      if (iRst) begin
         fval_q      <= 1'b0;
         acc_bank_q  <= 1'b0;
         disp_sel_q  <= 1'b1;
         disp_en_q   <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_addr_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_addr_q   <= '0;
         s2_data_q   <= '0;
         target_q    <= '0;
         sum_q       <= '0;
         max_q       <= '0;
         thr_q       <= '1;
         found_q     <= 1'b0;
         max_out_q   <= '0;
         thresh_q    <= THRESH_RST;
         pix_q       <= '0;
         pix_valid_q <= 1'b0;
         done_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         fval_q     <= iFval;
         disp_sel_q <= ~acc_bank_q;
         disp_en_q  <= ~init_clr;
         s1_valid_q <= pix_accept;
         s1_addr_q  <= iGray;
         s2_valid_q <= s1_valid_q;
         s2_addr_q  <= s1_addr_q;
         s2_data_q  <= inc_data;
         if ((state_q == StAccum) && fval_fall) target_q <= iTarget;
         if (state_q == StFlush) begin
            sum_q   <= '0;
            max_q   <= '0;
            thr_q   <= '1;
            found_q <= 1'b0;
         end else if (scanning) begin
            sum_q <= sum_d;
            if (acc_rdata > max_q) max_q <= acc_rdata;
            if (!found_q && (sum_d >= target_q)) begin
               thr_q   <= cnt_q;
               found_q <= 1'b1;
            end
         end
         if (publish) begin
            acc_bank_q <= ~acc_bank_q;
            max_out_q  <= max_q;
         end
         if (iManual) begin
            thresh_q <= iManualThresh;
         end else if (publish) begin
            thresh_q <= thr_q;
         end
         pix_q       <= (iGray >= thresh_q) ? '1 : '0;
         pix_valid_q <= iGrayValid;
         done_q      <= publish;
         overrun_q   <= fval_rise & (state_q != StIdle);
      end
   end

   assign oHisto      = disp_en_q ? (disp_sel_q ? rd_b : rd_a) : '0;
   assign oCumHisto   = disp_en_q ? rd_c : '0;
   assign oMaxValue   = max_out_q;
   assign oThresh     = thresh_q;
   assign oPixel      = pix_q;
   assign oPixelValid = pix_valid_q;
   assign oDone       = done_q;
   assign oOverrun    = overrun_q;

endmodule

// File: tb/tb_histo_thresh_engine.sv
// Bench for histo_thresh_engine: a 20-bit and a 4-bit counter instance share one stimulus.
module tb_histo_thresh_engine;

   localparam int NB   = 256;
   localparam int MAXC = (1 << 20) - 1;
   localparam int MAXS = 15;

   logic        iClk = 1'b0;
   logic        iRst = 1'b1;
   logic        iFval = 1'b0;
   logic        iGrayValid = 1'b0;
   logic        iManual = 1'b0;
   logic [7:0]  iGray = '0;
   logic [7:0]  iManualThresh = '0;
   logic [7:0]  iRdAddr = '0;
   logic [19:0] iTarget = '0;

   logic [19:0] oHisto, oCumHisto, oMaxValue;
   logic [7:0]  oThresh, oPixel;
   logic        oPixelValid, oDone, oOverrun;
   logic [3:0]  s_histo, s_cum, s_max;
   logic [7:0]  s_thresh, s_pixel;
   logic        s_pixel_valid, s_done, s_overrun;

   int n_checks = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int ovr_cnt = 0;

   int pix_q[$];
   int exp_h[NB], exp_c[NB], exp_hs[NB], exp_cs[NB];
   int exp_max, exp_maxs, exp_thr;

   always #5 iClk = ~iClk;

   histo_thresh_engine #(.PIX_W(8), .CNT_W(20)) dut (
      .iClk(iClk), .iRst(iRst), .iFval(iFval), .iGray(iGray), .iGrayValid(iGrayValid),
      .iTarget(iTarget), .iManual(iManual), .iManualThresh(iManualThresh), .iRdAddr(iRdAddr),
      .oHisto(oHisto), .oCumHisto(oCumHisto), .oMaxValue(oMaxValue), .oThresh(oThresh),
      .oPixel(oPixel), .oPixelValid(oPixelValid), .oDone(oDone), .oOverrun(oOverrun)
   );

   histo_thresh_engine #(.PIX_W(8), .CNT_W(4)) dut_s (
      .iClk(iClk), .iRst(iRst), .iFval(iFval), .iGray(iGray), .iGrayValid(iGrayValid),
      .iTarget(iTarget[3:0]), .iManual(iManual), .iManualThresh(iManualThresh),
      .iRdAddr(iRdAddr), .oHisto(s_histo), .oCumHisto(s_cum), .oMaxValue(s_max),
      .oThresh(s_thresh), .oPixel(s_pixel), .oPixelValid(s_pixel_valid), .oDone(s_done),
      .oOverrun(s_overrun)
   );

   always @(negedge iClk) begin
      if (oDone === 1'b1) done_cnt++;
      if (oOverrun === 1'b1) ovr_cnt++;
   end

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic apply_reset();
      iRst = 1'b1;
      iFval = 1'b0;
      iGrayValid = 1'b0;
      repeat (2) tick();
   endtask

   task automatic release_reset();
      iRst = 1'b0;
      repeat (NB + 4) tick();
   endtask

   task automatic drive_frame();
      iFval = 1'b1;
      tick();
      foreach (pix_q[i]) begin
         iGray = 8'(pix_q[i]);
         iGrayValid = 1'b1;
         tick();
      end
      iGrayValid = 1'b0;
      tick();
      iFval = 1'b0;
   endtask

   task automatic wait_done(output int cycles, output bit seen);
      seen = 1'b0;
      cycles = 0;
      while (!seen && cycles < 1000) begin
         tick();
         cycles++;
         if (oDone === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic read_bin(input int addr, output logic [31:0] h, output logic [31:0] c,
                           output logic [31:0] hs, output logic [31:0] cs);
      iRdAddr = 8'(addr);
      tick();
      h = 32'(oHisto);
      c = 32'(oCumHisto);
      hs = 32'(s_histo);
      cs = 32'(s_cum);
   endtask

   task automatic build_model(input int target);
      int cnt[NB];
      int sum, sums;
      bit found;
      foreach (cnt[b]) cnt[b] = 0;
      foreach (pix_q[i]) cnt[pix_q[i]]++;
      sum = 0; sums = 0; found = 1'b0;
      exp_max = 0; exp_maxs = 0; exp_thr = NB - 1;
      for (int b = 0; b < NB; b++) begin
         exp_h[b] = (cnt[b] > MAXC) ? MAXC : cnt[b];
         exp_hs[b] = (cnt[b] > MAXS) ? MAXS : cnt[b];
         sum = sum + exp_h[b];
         if (sum > MAXC) sum = MAXC;
         sums = sums + exp_hs[b];
         if (sums > MAXS) sums = MAXS;
         exp_c[b] = sum;
         exp_cs[b] = sums;
         if (exp_h[b] > exp_max) exp_max = exp_h[b];
         if (exp_hs[b] > exp_maxs) exp_maxs = exp_hs[b];
         if (!found && sum >= target) begin
            exp_thr = b;
            found = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if ({oHisto, oCumHisto, oMaxValue} !== 60'd0) begin
         n_fail++;
         $display("FAIL reset_counts: histo=%0h cum=%0h max=%0h, want 0", oHisto, oCumHisto,
                  oMaxValue);
      end
      n_checks++;
      if (oThresh !== 8'd128 || s_thresh !== 8'd128) begin
         n_fail++;
         $display("FAIL reset_thresh: got %0d/%0d, want 128", oThresh, s_thresh);
      end
      n_checks++;
      if ({oPixel, oPixelValid, oDone, oOverrun} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_flags: pix=%0h pv=%0b done=%0b ovr=%0b, want 0", oPixel,
                  oPixelValid, oDone, oOverrun);
      end
      release_reset();
   endtask

   task automatic test_uniform();
      int cyc, eh, ec;
      bit seen;
      logic [31:0] h, c, hs, cs;
      int qh[$], qc[$];
      pix_q.delete();
      repeat (16) pix_q.push_back(10);
      build_model(8);
      iTarget = 20'd8;
      drive_frame();
      wait_done(cyc, seen);
      n_checks++;
      if (!seen || cyc != 260) begin
         n_fail++;
         $display("FAIL done_latency: got %0d cycles (seen=%0b), want 260", cyc, seen);
      end
      n_checks++;
      if (oMaxValue !== 20'(exp_max)) begin
         n_fail++;
         $display("FAIL uniform_max: got %0d, want %0d", oMaxValue, exp_max);
      end
      n_checks++;
      if (oThresh !== 8'(exp_thr)) begin
         n_fail++;
         $display("FAIL uniform_thresh: got %0d, want %0d", oThresh, exp_thr);
      end
      tick();
      n_checks++;
      if (oDone !== 1'b0) begin
         n_fail++;
         $display("FAIL done_pulse_width: oDone=%0b one cycle later, want 0", oDone);
      end
      for (int b = 0; b < NB; b++) begin
         qh.push_back(exp_h[b]);
         qc.push_back(exp_c[b]);
         read_bin(b, h, c, hs, cs);
         eh = qh.pop_front();
         ec = qc.pop_front();
         n_checks++;
         if (h !== 32'(eh) || c !== 32'(ec)) begin
            n_fail++;
            $display("FAIL uniform_bin[%0d]: histo=%0d cum=%0d, want %0d/%0d", b, h, c, eh, ec);
         end
      end
      repeat (4) tick();
   endtask

   task automatic test_bypass();
      int cyc, e;
      bit seen;
      logic [31:0] h, c, hs, cs;
      int qh[$];
      pix_q.delete();
      repeat (4) begin
         pix_q.push_back(5); pix_q.push_back(5); pix_q.push_back(6); pix_q.push_back(5);
      end
      build_model(16);
      iTarget = 20'd16;
      drive_frame();
      wait_done(cyc, seen);
      n_checks++;
      if (!seen || oMaxValue !== 20'(exp_max) || oThresh !== 8'(exp_thr)) begin
         n_fail++;
         $display("FAIL bypass_publish: seen=%0b max=%0d thr=%0d, want max %0d thr %0d", seen,
                  oMaxValue, oThresh, exp_max, exp_thr);
      end
      for (int b = 4; b < 8; b++) begin
         qh.push_back(exp_h[b]);
         read_bin(b, h, c, hs, cs);
         e = qh.pop_front();
         n_checks++;
         if (h !== 32'(e)) begin
            n_fail++;
            $display("FAIL bypass_bin[%0d]: got %0d, want %0d", b, h, e);
         end
      end
      read_bin(255, h, c, hs, cs);
      n_checks++;
      if (c !== 32'(exp_c[255])) begin
         n_fail++;
         $display("FAIL bypass_cum255: got %0d, want %0d", c, exp_c[255]);
      end
      repeat (NB + 4) tick();
   endtask

   task automatic test_ramp();
      int targets[3] = '{0, 300, 128};
      int thr_want[3] = '{0, 255, 127};
      int gray_in[5] = '{0, 126, 127, 128, 255};
      int cyc, e;
      bit seen;
      logic [31:0] h, c, hs, cs;
      int qp[$];
      pix_q.delete();
      for (int g = 0; g < NB; g++) pix_q.push_back(g);
      for (int k = 0; k < 3; k++) begin
         iTarget = 20'(targets[k]);
         drive_frame();
         tick();
         // Free-running pixels across publish; valid is ignored outside accumulation.
         iGray = 8'd200;
         iGrayValid = 1'b1;
         wait_done(cyc, seen);
         n_checks++;
         if (!seen || oThresh !== 8'(thr_want[k])) begin
            n_fail++;
            $display("FAIL ramp_thresh[t=%0d]: seen=%0b got %0d, want %0d", targets[k], seen,
                     oThresh, thr_want[k]);
         end
         if (k == 2) begin
            n_checks++;
            if (oPixel !== 8'h00) begin
               n_fail++;
               $display("FAIL thresh_switch_old: pixel=%0h at oDone, want 00", oPixel);
            end
            tick();
            n_checks++;
            if (oPixel !== 8'hFF) begin
               n_fail++;
               $display("FAIL thresh_switch_new: pixel=%0h after oDone, want ff", oPixel);
            end
         end
         iGrayValid = 1'b0;
         read_bin(200, h, c, hs, cs);
         n_checks++;
         if (h !== 32'd1 || c !== 32'd201) begin
            n_fail++;
            $display("FAIL ramp_bin200: histo=%0d cum=%0d, want 1/201", h, c);
         end
         repeat (NB + 4) tick();
      end
      for (int i = 0; i < 5; i++) begin
         qp.push_back((gray_in[i] >= 127) ? 255 : 0);
         iGray = 8'(gray_in[i]);
         iGrayValid = 1'b1;
         tick();
         e = qp.pop_front();
         n_checks++;
         if (oPixel !== 8'(e) || oPixelValid !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_pixel[%0d]: pixel=%0h valid=%0b, want %0h/1", gray_in[i], oPixel,
                     oPixelValid, e);
         end
      end
      iGrayValid = 1'b0;
      tick();
      n_checks++;
      if (oPixelValid !== 1'b0) begin
         n_fail++;
         $display("FAIL pixel_valid_drop: got %0b, want 0", oPixelValid);
      end
   endtask

   task automatic test_manual();
      int gray_in[2] = '{49, 50};
      int cyc, e;
      bit seen;
      int qp[$];
      iManual = 1'b1;
      iManualThresh = 8'd50;
      tick();
      n_checks++;
      if (oThresh !== 8'd50) begin
         n_fail++;
         $display("FAIL manual_thresh: got %0d, want 50", oThresh);
      end
      for (int i = 0; i < 2; i++) begin
         qp.push_back((gray_in[i] >= 50) ? 255 : 0);
         iGray = 8'(gray_in[i]);
         iGrayValid = 1'b1;
         tick();
         e = qp.pop_front();
         n_checks++;
         if (oPixel !== 8'(e)) begin
            n_fail++;
            $display("FAIL manual_pixel[%0d]: got %0h, want %0h", gray_in[i], oPixel, e);
         end
      end
      iGrayValid = 1'b0;
      pix_q.delete();
      repeat (4) pix_q.push_back(200);
      iTarget = 20'd1;
      drive_frame();
      wait_done(cyc, seen);
      tick();
      n_checks++;
      if (!seen || oThresh !== 8'd50 || oMaxValue !== 20'd4) begin
         n_fail++;
         $display("FAIL manual_keeps: seen=%0b thr=%0d max=%0d, want thr 50 max 4", seen,
                  oThresh, oMaxValue);
      end
      iManual = 1'b0;
      repeat (NB + 4) tick();
   endtask

   task automatic test_overrun();
      int cyc, d0, o0;
      bit seen;
      logic [31:0] h, c, hs, cs, h2;
      d0 = done_cnt;
      o0 = ovr_cnt;
      iTarget = 20'd1;
      pix_q.delete();
      repeat (16) pix_q.push_back(20);
      drive_frame();
      repeat (100) tick();
      pix_q.delete();
      repeat (16) pix_q.push_back(30);
      drive_frame();
      wait_done(cyc, seen);
      repeat (NB + 8) tick();
      n_checks++;
      if (!seen || ovr_cnt - o0 != 1 || done_cnt - d0 != 1) begin
         n_fail++;
         $display("FAIL overrun_pulse: seen=%0b overruns=%0d dones=%0d, want 1/1", seen,
                  ovr_cnt - o0, done_cnt - d0);
      end
      read_bin(20, h, c, hs, cs);
      read_bin(30, h2, c, hs, cs);
      n_checks++;
      if (h !== 32'd16 || h2 !== 32'd0) begin
         n_fail++;
         $display("FAIL overrun_published: bin20=%0d bin30=%0d, want 16/0", h, h2);
      end
      pix_q.delete();
      repeat (8) pix_q.push_back(40);
      drive_frame();
      wait_done(cyc, seen);
      read_bin(40, h, c, hs, cs);
      read_bin(20, h2, c, hs, cs);
      n_checks++;
      if (!seen || h !== 32'd8 || h2 !== 32'd0 || ovr_cnt - o0 != 1) begin
         n_fail++;
         $display("FAIL overrun_next_frame: seen=%0b bin40=%0d bin20=%0d ovr=%0d, want 8/0/1",
                  seen, h, h2, ovr_cnt - o0);
      end
      repeat (NB + 4) tick();
   endtask

   task automatic test_saturation();
      int cyc;
      bit seen;
      logic [31:0] h, c, hs, cs;
      pix_q.delete();
      repeat (20) pix_q.push_back(3);
      build_model(1);
      iTarget = 20'd1;
      drive_frame();
      wait_done(cyc, seen);
      n_checks++;
      if (!seen || s_max !== 4'(exp_maxs) || oMaxValue !== 20'(exp_max)) begin
         n_fail++;
         $display("FAIL sat_max: seen=%0b narrow=%0d wide=%0d, want %0d/%0d", seen, s_max,
                  oMaxValue, exp_maxs, exp_max);
      end
      read_bin(3, h, c, hs, cs);
      n_checks++;
      if (hs !== 32'(exp_hs[3]) || h !== 32'(exp_h[3])) begin
         n_fail++;
         $display("FAIL sat_bin3: narrow=%0d wide=%0d, want %0d/%0d", hs, h, exp_hs[3],
                  exp_h[3]);
      end
      read_bin(255, h, c, hs, cs);
      n_checks++;
      if (cs !== 32'(exp_cs[255])) begin
         n_fail++;
         $display("FAIL sat_cum255: got %0d, want %0d", cs, exp_cs[255]);
      end
      repeat (NB + 4) tick();
   endtask

   task automatic test_reset_mid();
      int cyc;
      bit seen;
      logic [31:0] h, c, hs, cs;
      iFval = 1'b1;
      tick();
      iGray = 8'd7;
      iGrayValid = 1'b1;
      repeat (10) tick();
      apply_reset();
      n_checks++;
      if ({oHisto, oCumHisto, oMaxValue, oPixel, oPixelValid, oDone, oOverrun} !== 71'd0 ||
          oThresh !== 8'd128 || s_max !== 4'd0 || s_thresh !== 8'd128) begin
         n_fail++;
         $display("FAIL midreset_outputs: histo=%0d cum=%0d max=%0d thr=%0d pix=%0h", oHisto,
                  oCumHisto, oMaxValue, oThresh, oPixel);
      end
      release_reset();
      pix_q.delete();
      repeat (4) pix_q.push_back(7);
      iTarget = 20'd1;
      drive_frame();
      wait_done(cyc, seen);
      read_bin(7, h, c, hs, cs);
      n_checks++;
      if (!seen || h !== 32'd4 || hs !== 32'd4) begin
         n_fail++;
         $display("FAIL midreset_recount: seen=%0b bin7=%0d/%0d, want 4/4", seen, h, hs);
      end
      repeat (NB + 4) tick();
   endtask

   initial begin
      test_reset();
      test_uniform();
      test_bypass();
      test_ramp();
      test_manual();
      test_overrun();
      test_saturation();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/histo_thresh_engine.md
# histo_thresh_engine

Parametrised histogram/threshold engine for the camera pipeline: accumulates a per-frame histogram of the gray stream and derives a percentile threshold from the cumulative histogram. It exposes histogram, cumulative histogram and peak to the histogram displayers, and binarises the gray stream. It supersedes the fixed 8-bit histogram/threshold path with ping-pong banks, a frame-accurate publish point and a manual-threshold mode. It sits between the RGB→gray converter and the display arbitrator.

## Interface
- PIX_W, 8: gray width; bins = 2^PIX_W
- CNT_W, 20: bin/cumulative counter width
- THRESH_RST, 2^(PIX_W-1): oThresh value after reset
- iClk  in  1  single clock
- iRst  in  1  synchronous, active-high reset
- iFval  in  1  frame valid
- iGray  in  PIX_W  gray pixel
- iGrayValid  in  1  iGray qualifier
- iTarget  in  CNT_W  percentile target count; sampled at frame end
- iManual  in  1  1 = use iManualThresh
- iManualThresh  in  PIX_W  manual threshold
- iRdAddr  in  PIX_W  display read bin
- oHisto  out  CNT_W  published histogram[iRdAddr]
- oCumHisto  out  CNT_W  published cumulative[iRdAddr]
- oMaxValue  out  CNT_W  largest published bin
- oThresh  out  PIX_W  active threshold
- oPixel  out  PIX_W  all-ones if iGray >= oThresh, else 0
- oPixelValid  out  1  oPixel qualifier
- oDone  out  1  one-cycle pulse at publish
- oOverrun  out  1  one-cycle pulse on dropped frame

## Operation
- Storage: two histogram banks (A/B) plus one cumulative RAM, each 2^PIX_W × CNT_W, 1-cycle read latency. acc_bank = bank being filled; pub_bank = bank read by display (always the other bank).
- FSM: INIT_CLEAR → IDLE → ACCUM → FLUSH → SCAN → PUBLISH → CLEAR → IDLE.
- INIT_CLEAR (entered on reset): zero both banks and cumulative RAM, 2^PIX_W cycles; acc_bank=A.
- IDLE: iFval rising edge → ACCUM.
- ACCUM: each iGrayValid does read-modify-write +1 on acc_bank[iGray]; 2-stage pipeline with bypass so back-to-back or alternating equal bins count exactly. Bins saturate at 2^CNT_W-1. iFval falling edge → FLUSH, iTarget latched.
- FLUSH: 2 cycles to drain the increment pipeline → SCAN.
- SCAN: bin 0..2^PIX_W-1 read in order; running sum (saturating) written to cumulative RAM; track max bin; thr = first bin with sum >= target; if none, thr = 2^PIX_W-1; target 0 gives 0.
- PUBLISH (1 cycle): pub_bank←acc_bank, oMaxValue←max, oThresh←thr (unless iManual), oDone=1.
- CLEAR: zero the new acc_bank (old pub_bank), 2^PIX_W cycles → IDLE.
- Cumulative RAM writes during SCAN are visible to display immediately (no double buffer); accepted tearing of one frame.
- iFval rising outside IDLE: that frame is not accumulated, oOverrun pulses once; engine waits for next rising edge in IDLE.
- iGrayValid outside ACCUM ignored.
- iManual=1: oThresh = iManualThresh registered every cycle; SCAN still runs, result discarded.
- Thresholder independent of FSM; runs every cycle.

## Timing
- Reset values: oHisto, oCumHisto, oMaxValue, oPixel, oPixelValid, oDone, oOverrun = 0; oThresh = THRESH_RST; FSM = INIT_CLEAR.
- Reset mid-frame: accumulated data discarded, INIT_CLEAR re-run.
- oHisto/oCumHisto: 1 cycle after iRdAddr.
- oPixel/oPixelValid: 1 cycle after iGray/iGrayValid, compared against oThresh at that cycle.
- Frame-end to oDone: 2 (edge detect + FLUSH…) — exactly 1 + 2 + 2^PIX_W + 1 cycles after the first cycle iFval is low.
- Threshold change takes effect on the pixel sampled the cycle after oDone.
- Minimum blanking for no overrun: 2^(PIX_W+1) + 4 cycles.

## Structure
- Package histo_pkg: FSM state enum, bin-count/saturation helpers, THRESH_RST default.
- Sub-module histo_bank_ram: single-port-write / separate-read 1-cycle RAM, instantiated three times.
- Thresholder comparison inline.

## Test plan
- Reset, 4×4 frame all gray=10 (PIX_W=8) → after oDone oHisto[10]=16, others 0, oMaxValue=16, oCumHisto[255]=16.
- 16 consecutive pixels alternating 5,5,6,5 → bins 5=12, 6=4 (bypass correctness).
- Ramp 0..255 one each, iTarget=128 → oThresh=127; iTarget=0 → 0; iTarget=300 → 255.
- iManual=1, iManualThresh=50, gray 49/50 → oPixel 0x00/0xFF one cycle later.
- Second frame starts 100 cycles after first ends → oOverrun pulse, published data unchanged, third frame accumulates normally.
- CNT_W=4, 20 pixels of gray 3 → oHisto[3]=15 (saturation); iRst mid-ACCUM → all outputs at reset values, next frame counts start from 0.
